// File: rtl/exe_stage.sv
// Execute stage: Val2 generator, ALU with NZCV flags, branch-target adder, status and EXE/MEM registers.
// Define STATUS_BYPASS_EN to forward the flags being written this cycle straight onto status.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [3:0]       exe_cmd,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic             b_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      imm24,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [3:0]       dest_in,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_address,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [3:0]       dest_out,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             valid_out
);

  // Handshake: valid_in qualifies the ID/EXE slot and valid_out the EXE/MEM slot; there is no
  // ready path, freeze is the only backpressure and it holds both the status and EXE/MEM registers.

  function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] v, input logic [4:0] n);
    logic [2*WIDTH-1:0] w_dbl;
    w_dbl = {v, v} >> n;
    return w_dbl[WIDTH-1:0];
  endfunction

  logic [3:0]       r_status;
  logic [WIDTH-1:0] r_alu_result;
  logic [WIDTH-1:0] r_val_rm;
  logic [3:0]       r_dest;
  logic             r_wb_en;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_valid;

  logic [WIDTH-1:0] w_val2;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_new_status;
  logic             w_status_we;
  logic [4:0]       w_sh_amt;
  logic [4:0]       w_rot_amt;
  logic [WIDTH-1:0] w_imm8;

  assign w_sh_amt  = shift_operand[11:7];
  assign w_rot_amt = {shift_operand[11:8], 1'b0};
  assign w_imm8    = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
  assign w_cin     = r_status[1];

  // Memory ops use the raw 12-bit offset; otherwise rotated immediate or shifted Rm.
  always_comb begin
    w_val2 = '0;
    if (mem_r_en_in | mem_w_en_in) begin
      w_val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    end else if (imm_in) begin
      w_val2 = ror_w(w_imm8, w_rot_amt);
    end else begin
      case (shift_operand[6:5])
        2'b00:   w_val2 = val_rm << w_sh_amt;
        2'b01:   w_val2 = val_rm >> w_sh_amt;
        2'b10:   w_val2 = $signed(val_rm) >>> w_sh_amt;
        default: w_val2 = ror_w(val_rm, w_sh_amt);
      endcase
    end
  end

  // Subtraction is Rn + ~Val2 + carry, so C comes out as NOT borrow directly.
  always_comb begin
    w_alu = '0;
    w_sum = '0;
    w_c   = r_status[1];
    w_v   = r_status[0];
    case (exe_cmd)
      4'b0001: w_alu = w_val2;
      4'b1001: w_alu = ~w_val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, val_rn} + {1'b0, w_val2} + {{WIDTH{1'b0}}, exe_cmd[0] & w_cin};
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (val_rn[WIDTH-1] == w_val2[WIDTH-1]) && (w_alu[WIDTH-1] != val_rn[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        w_sum = {1'b0, val_rn} + {1'b0, ~w_val2} + {{WIDTH{1'b0}}, exe_cmd[0] ? w_cin : 1'b1};
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (val_rn[WIDTH-1] != w_val2[WIDTH-1]) && (w_alu[WIDTH-1] != val_rn[WIDTH-1]);
      end
      4'b0110: w_alu = val_rn & w_val2;
      4'b0111: w_alu = val_rn | w_val2;
      4'b1000: w_alu = val_rn ^ w_val2;
      default: w_alu = '0;
    endcase
  end

  assign w_new_status = {w_alu[WIDTH-1], (w_alu == '0), w_c, w_v};
  assign w_status_we  = s_in & valid_in & ~freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
    end else if (w_status_we) begin
      r_status <= w_new_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_result <= '0;
      r_val_rm     <= '0;
      r_dest       <= '0;
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_valid      <= 1'b0;
    end else if (!freeze) begin
      r_alu_result <= w_alu;
      r_val_rm     <= val_rm;
      r_dest       <= dest_in;
      r_wb_en      <= wb_en_in & valid_in;
      r_mem_r_en   <= mem_r_en_in & valid_in;
      r_mem_w_en   <= mem_w_en_in & valid_in;
      r_valid      <= valid_in;
    end
  end

  assign branch_taken   = b_in & valid_in & ~freeze;
  assign branch_address = pc_in + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

`ifdef STATUS_BYPASS_EN
  assign status = w_status_we ? w_new_status : r_status;
`else
  assign status = r_status;
`endif

  assign alu_result_out = r_alu_result;
  assign val_rm_out     = r_val_rm;
  assign dest_out       = r_dest;
  assign wb_en_out      = r_wb_en;
  assign mem_r_en_out   = r_mem_r_en;
  assign mem_w_en_out   = r_mem_w_en;
  assign valid_out      = r_valid;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: table of ALU/Val2 vectors checked through a result queue, plus
// hand sequences for reset, branch, freeze, bubble and reset mid-stream.
module tb_exe_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze, valid_in;
  logic [31:0] pc_in;
  logic [3:0]  exe_cmd;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in;
  logic [11:0] shift_operand;
  logic [23:0] imm24;
  logic [31:0] val_rn, val_rm;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status;
  logic [31:0] alu_result_out, val_rm_out;
  logic [3:0]  dest_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, valid_out;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
    .exe_cmd(exe_cmd), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .s_in(s_in), .b_in(b_in), .imm_in(imm_in),
    .shift_operand(shift_operand), .imm24(imm24), .val_rn(val_rn), .val_rm(val_rm),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_address(branch_address),
    .status(status), .alu_result_out(alu_result_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .valid_out(valid_out)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        mr;
    logic        mw;
    logic [11:0] so;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  localparam int NV = 24;
  vec_t        vecs[NV];
  logic [70:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        pend;

  function automatic vec_t mk(input logic [3:0] cmd, input logic s, input logic imm,
                              input logic mr, input logic mw, input logic [11:0] so,
                              input logic [31:0] rn, input logic [31:0] rm,
                              input logic [31:0] res, input logic [3:0] st);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw; v.so = so;
    v.rn = rn; v.rm = rm; v.exp_res = res; v.exp_st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one live instruction; the expected EXE/MEM record is queued only if it will be captured.
  task automatic drive_op(input vec_t v, input logic [3:0] dest);
    valid_in = 1'b1; exe_cmd = v.cmd; s_in = v.s; imm_in = v.imm;
    mem_r_en_in = v.mr; mem_w_en_in = v.mw; wb_en_in = 1'b1; b_in = 1'b0;
    shift_operand = v.so; val_rn = v.rn; val_rm = v.rm; dest_in = dest;
    if (!freeze && !rst) begin
      exp_q.push_back({v.exp_res, v.rm, dest, 1'b1, v.mr, v.mw});
      pend = 1'b1;
    end
  endtask

  task automatic tick();
    logic was_frozen, was_rst;
    logic [70:0] exp;
    was_frozen = freeze;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (!was_frozen && !was_rst && valid_out) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 71'(valid_out), 71'(0));
      end else begin
        exp = exp_q.pop_front();
        check("sb_exemem", {alu_result_out, val_rm_out, dest_out, wb_en_out, mem_r_en_out,
                            mem_w_en_out}, exp);
      end
    end else if (pend && !was_rst) begin
      check("sb_missing_valid", 71'(valid_out), 71'(1));
    end
    pend = 1'b0;
    valid_in = 1'b0; s_in = 1'b0; b_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(4'b0100, 1, 1, 0, 0, 12'h005, 32'd5,        $urandom(),   32'h0,        4'b0110);
    vecs[1]  = mk(4'b0100, 1, 1, 0, 0, 12'h005, 32'd3,        $urandom(),   32'hFFFFFFFE, 4'b1000);
    vecs[2]  = mk(4'b0010, 1, 1, 0, 0, 12'h001, 32'h7FFFFFFF, $urandom(),   32'h80000000, 4'b1001);
    vecs[3]  = mk(4'b0010, 1, 1, 0, 0, 12'h001, 32'hFFFFFFFF, $urandom(),   32'h0,        4'b0110);
    vecs[4]  = mk(4'b0011, 0, 1, 0, 0, 12'h001, 32'd1,        $urandom(),   32'd3,        4'b0110);
    vecs[5]  = mk(4'b0001, 0, 1, 0, 0, 12'h4FF, $urandom(),   $urandom(),   32'hFF000000, 4'b0110);
    vecs[6]  = mk(4'b0001, 0, 0, 0, 0, 12'h0E3, $urandom(),   32'h80000001, 32'hC0000000, 4'b0110);
    vecs[7]  = mk(4'b0001, 0, 0, 0, 0, 12'h240, $urandom(),   32'h80000000, 32'hF8000000, 4'b0110);
    vecs[8]  = mk(4'b0010, 0, 1, 1, 0, 12'hFFF, 32'h1000,     $urandom(),   32'h1FFF,     4'b0110);
    vecs[9]  = mk(4'b0101, 1, 1, 0, 0, 12'h003, 32'd10,       $urandom(),   32'd7,        4'b0010);
    vecs[10] = mk(4'b0100, 1, 1, 0, 0, 12'h001, 32'd0,        $urandom(),   32'hFFFFFFFF, 4'b1000);
    vecs[11] = mk(4'b0101, 1, 1, 0, 0, 12'h003, 32'd10,       $urandom(),   32'd6,        4'b0010);
    vecs[12] = mk(4'b0110, 1, 1, 0, 0, 12'h0FF, 32'hF00,      $urandom(),   32'h0,        4'b0110);
    vecs[13] = mk(4'b0111, 1, 1, 0, 0, 12'h001, 32'h80000000, $urandom(),   32'h80000001, 4'b1010);
    vecs[14] = mk(4'b1000, 0, 1, 0, 0, 12'h0FF, 32'hFF,       $urandom(),   32'h0,        4'b1010);
    vecs[15] = mk(4'b1001, 1, 1, 0, 0, 12'h0FF, $urandom(),   $urandom(),   32'hFFFFFF00, 4'b1010);
    vecs[16] = mk(4'b0000, 1, 1, 0, 0, 12'h001, 32'd5,        $urandom(),   32'h0,        4'b0110);
    vecs[17] = mk(4'b0100, 1, 1, 0, 0, 12'h001, 32'h80000000, $urandom(),   32'h7FFFFFFF, 4'b0011);
    vecs[18] = mk(4'b0001, 0, 0, 0, 0, 12'h200, $urandom(),   32'h3,        32'h30,       4'b0011);
    vecs[19] = mk(4'b0001, 0, 0, 0, 0, 12'h220, $urandom(),   32'hF0000000, 32'h0F000000, 4'b0011);
    vecs[20] = mk(4'b0001, 0, 0, 0, 0, 12'h060, $urandom(),   32'h12345678, 32'h12345678, 4'b0011);
    vecs[21] = mk(4'b0010, 0, 0, 0, 1, 12'h004, 32'h2000,     32'hDEADBEEF, 32'h2004,     4'b0011);
    vecs[22] = mk(4'b0011, 1, 1, 0, 0, 12'h001, 32'hFFFFFFFF, $urandom(),   32'h1,        4'b0010);
    vecs[23] = mk(4'b0001, 0, 0, 0, 0, 12'h2C0, $urandom(),   32'h7FFFFFFF, 32'h03FFFFFF, 4'b0010);

    pend = 1'b0;
    pc_in = '0; imm24 = '0; b_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    dest_in = 4'hF; val_rm = 32'hA5A5A5A5;
    // Reset with a live, frozen S-instruction on the inputs: reset must still clear everything.
    rst = 1'b1; freeze = 1'b1; valid_in = 1'b1; wb_en_in = 1'b1; s_in = 1'b1;
    exe_cmd = 4'b0100; val_rn = 32'd5; imm_in = 1'b1; shift_operand = 12'h005;
    @(posedge clk); @(posedge clk); #1;
    check("rst_status", 71'(status), 71'(0));
    check("rst_alu", 71'(alu_result_out), 71'(0));
    check("rst_ctrl", 71'({wb_en_out, mem_r_en_out, mem_w_en_out, valid_out}), 71'(0));
    check("rst_data", 71'({val_rm_out, dest_out}), 71'(0));
    rst = 1'b0; freeze = 1'b0; valid_in = 1'b0; s_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive_op(vecs[i], 4'(i));
`ifdef STATUS_BYPASS_EN
      #1;
      check($sformatf("bypass_status_%0d", i), 71'(status), 71'(vecs[i].exp_st));
`endif
      tick();
      check($sformatf("status_%0d", i), 71'(status), 71'(vecs[i].exp_st));
    end

    // Branch with S set: taken, correct target, and flags updated.
    drive_op(mk(4'b0100, 1, 1, 0, 0, 12'h005, 32'd5, 32'h0, 32'h0, 4'b0110), 4'd2);
    b_in = 1'b1; pc_in = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    check("br_taken", 71'(branch_taken), 71'(1));
    check("br_addr", 71'(branch_address), 71'(32'hF8));
    freeze = 1'b1; #1;
    check("br_frozen", 71'(branch_taken), 71'(0));
    freeze = 1'b0; #1;
    tick();
    check("br_status", 71'(status), 71'(4'b0110));
    pc_in = 32'hFFFFFFFC; imm24 = 24'h000002; b_in = 1'b1; valid_in = 1'b1; #1;
    check("br_wrap", 71'(branch_address), 71'(32'h4));
    valid_in = 1'b0; #1;
    check("br_bubble", 71'(branch_taken), 71'(0));
    b_in = 1'b0;

    // Freeze for three cycles while a flag-setting op sits on the inputs.
    drive_op(mk(4'b0010, 1, 1, 0, 0, 12'h001, 32'd1, 32'h11, 32'd2, 4'b0000), 4'd7);
    tick();
    check("frz_pre_status", 71'(status), 71'(0));
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_op(mk(4'b0100, 1, 1, 0, 0, 12'h005, 32'd5, 32'h22, 32'h0, 4'b0110), 4'd9);
      tick();
      check($sformatf("frz_hold_%0d", k), {alu_result_out, val_rm_out, dest_out, valid_out,
            status[2:0]}, {32'd2, 32'h11, 4'd7, 1'b1, 3'b000});
      check($sformatf("frz_status_%0d", k), 71'(status), 71'(0));
    end
    freeze = 1'b0;

    // Bubble: enables and S must be masked by valid_in.
    valid_in = 1'b0; wb_en_in = 1'b1; mem_w_en_in = 1'b1; s_in = 1'b1;
    exe_cmd = 4'b0100; imm_in = 1'b1; shift_operand = 12'h005; val_rn = 32'd5;
    tick();
    check("bub_ctrl", 71'({wb_en_out, mem_w_en_out, valid_out}), 71'(0));
    check("bub_status", 71'(status), 71'(0));
    mem_w_en_in = 1'b0;

    // Reset mid-stream discards the in-flight slot and clears status.
    drive_op(mk(4'b0100, 1, 1, 0, 0, 12'h005, 32'd5, 32'h33, 32'h0, 4'b0110), 4'd3);
    tick();
    check("mid_pre_status", 71'(status), 71'(4'b0110));
    rst = 1'b1;
    drive_op(mk(4'b0010, 1, 1, 0, 0, 12'h001, 32'd8, 32'h44, 32'd9, 4'b0000), 4'd4);
    tick();
    rst = 1'b0;
    check("mid_valid", 71'({valid_out, wb_en_out}), 71'(0));
    check("mid_status", 71'(status), 71'(0));
    check("mid_alu", 71'(alu_result_out), 71'(0));

    check("sb_drain", 71'(exp_q.size()), 71'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
